// File: rtl/ram2video_reader.sv
// Reads buffered RGB lines from the dual-port RAM and regenerates a progressive raster.
// Optional macro RAM2VIDEO_RESYNC_EN: a trigger while running re-locks the raster to (0,0).
module ram2video_reader #(
    parameter int H_TOTAL            = 800,
    parameter int H_ACTIVE           = 640,
    parameter int H_SYNC_START       = 656,
    parameter int H_SYNC_END         = 752,
    parameter int V_TOTAL            = 525,
    parameter int V_ACTIVE           = 480,
    parameter int V_SYNC_START       = 490,
    parameter int V_SYNC_END         = 492,
    parameter int BUFFER_LINE_LENGTH = 640,
    parameter int RAM_NUMWORDS       = 10240,
    parameter int RAM_ADDRESS_BITS   = 14,
    parameter int RD_LATENCY         = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        starttrigger,
    input  logic [23:0]                 rddata,
    output logic [RAM_ADDRESS_BITS-1:0] rdaddr,
    output logic                        rden,
    output logic [23:0]                 video_out,
    output logic                        de,
    output logic                        hsync,
    output logic                        vsync,
    output logic [11:0]                 counterX,
    output logic [11:0]                 counterY,
    output logic                        running
);

    localparam int AW  = RAM_ADDRESS_BITS;
    localparam int AW1 = RAM_ADDRESS_BITS + 1;
    localparam int PD  = RD_LATENCY + 2;

    localparam logic [11:0]    LP_X_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]    LP_Y_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0]    LP_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0]    LP_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0]    LP_HS_START = 12'(H_SYNC_START);
    localparam logic [11:0]    LP_HS_END   = 12'(H_SYNC_END);
    localparam logic [11:0]    LP_VS_START = 12'(V_SYNC_START);
    localparam logic [11:0]    LP_VS_END   = 12'(V_SYNC_END);
    localparam logic [AW1-1:0] LP_LINE_LEN = AW1'(BUFFER_LINE_LENGTH);
    localparam logic [AW1-1:0] LP_NUMWORDS = AW1'(RAM_NUMWORDS);

    typedef enum logic {
        WAIT_TRIGGER,
        RUNNING
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [11:0]     r_cnt_x;
    logic [11:0]     r_cnt_y;
    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_rdaddr;
    logic            r_rden;
    logic [23:0]     r_video;
    logic [PD-1:0]   r_de_pipe;
    logic [PD-1:0]   r_hs_pipe;
    logic [PD-1:0]   r_vs_pipe;

    logic            w_running;
    logic            w_resync;
    logic            w_x_last;
    logic            w_y_last;
    logic            w_act;
    logic            w_hs;
    logic            w_vs;
    logic [AW1-1:0]  w_base_sum;
    logic            w_base_wrap;
    logic [AW-1:0]   w_rd_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= WAIT_TRIGGER;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_TRIGGER: if (starttrigger) w_state_next = RUNNING;
            RUNNING:      w_state_next = RUNNING;
            default:      w_state_next = WAIT_TRIGGER;
        endcase
    end

    assign w_running = (r_state == RUNNING);

`ifdef RAM2VIDEO_RESYNC_EN
    // A trigger landing exactly on (0,0) is already in lock, so it is ignored.
    assign w_resync = w_running && starttrigger && ((r_cnt_x != 12'd0) || (r_cnt_y != 12'd0));
`else
    assign w_resync = 1'b0;
`endif

    assign w_x_last = (r_cnt_x == LP_X_LAST);
    assign w_y_last = (r_cnt_y == LP_Y_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_x <= 12'd0;
            r_cnt_y <= 12'd0;
        end else if (!w_running || w_resync) begin
            r_cnt_x <= 12'd0;
            r_cnt_y <= 12'd0;
        end else if (w_x_last) begin
            r_cnt_x <= 12'd0;
            r_cnt_y <= w_y_last ? 12'd0 : r_cnt_y + 12'd1;
        end else begin
            r_cnt_x <= r_cnt_x + 12'd1;
        end
    end

    assign w_base_sum  = {1'b0, r_base} + LP_LINE_LEN;
    assign w_base_wrap = (w_base_sum >= LP_NUMWORDS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
        end else if (!w_running || w_resync) begin
            r_base <= '0;
        end else if (w_x_last) begin
            if (w_y_last)
                r_base <= '0;
            else if (r_cnt_y < LP_V_ACT)
                r_base <= w_base_wrap ? '0 : w_base_sum[AW-1:0];
        end
    end

    assign w_act     = w_running && (r_cnt_x < LP_H_ACT) && (r_cnt_y < LP_V_ACT);
    assign w_hs      = w_running && (r_cnt_x >= LP_HS_START) && (r_cnt_x < LP_HS_END);
    assign w_vs      = w_running && (r_cnt_y >= LP_VS_START) && (r_cnt_y < LP_VS_END);
    assign w_rd_addr = r_base + AW'(r_cnt_x);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdaddr <= '0;
            r_rden   <= 1'b0;
        end else begin
            r_rden <= w_act;
            if (w_act) r_rdaddr <= w_rd_addr;
        end
    end

    // Stage 0 lines up with rdaddr; stage RD_LATENCY lines up with the returning rddata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_video   <= 24'd0;
        end else begin
            r_de_pipe <= {r_de_pipe[PD-2:0], w_act};
            r_hs_pipe <= {r_hs_pipe[PD-2:0], w_hs};
            r_vs_pipe <= {r_vs_pipe[PD-2:0], w_vs};
            r_video   <= r_de_pipe[PD-2] ? rddata : 24'd0;
        end
    end

    assign rdaddr    = r_rdaddr;
    assign rden      = r_rden;
    assign video_out = r_video;
    assign de        = r_de_pipe[PD-1];
    assign hsync     = r_hs_pipe[PD-1];
    assign vsync     = r_vs_pipe[PD-1];
    assign counterX  = r_cnt_x;
    assign counterY  = r_cnt_y;
    assign running   = w_running;

endmodule

// File: tb/tb_ram2video_reader.sv
// Bench for ram2video_reader on a scaled-down raster with a random-content RAM model.
module tb_ram2video_reader;

    localparam int HT    = 48;
    localparam int HA    = 32;
    localparam int HSS   = 36;
    localparam int HSE   = 44;
    localparam int VT    = 40;
    localparam int VA    = 36;
    localparam int VSS   = 37;
    localparam int VSE   = 39;
    localparam int BUF   = 32;
    localparam int NW    = 512;
    localparam int AW    = 14;
    localparam int RL    = 2;
    localparam int FRAME = HT * VT;
    localparam int LINES = NW / BUF;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          starttrigger = 1'b0;
    logic [23:0]   rddata;
    logic [AW-1:0] rdaddr;
    logic          rden;
    logic [23:0]   video_out;
    logic          de, hsync, vsync;
    logic [11:0]   counterX, counterY;
    logic          running;

    int total = 0;
    int bad   = 0;

    logic [23:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] m_pipe [RL];

    ram2video_reader #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .BUFFER_LINE_LENGTH(BUF), .RAM_NUMWORDS(NW), .RAM_ADDRESS_BITS(AW),
        .RD_LATENCY(RL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .starttrigger(starttrigger),
        .rddata(rddata), .rdaddr(rdaddr), .rden(rden), .video_out(video_out),
        .de(de), .hsync(hsync), .vsync(vsync),
        .counterX(counterX), .counterY(counterY), .running(running)
    );

    always #5 clock = ~clock;

    // RAM read port: data for an address appears RL clocks after it is presented.
    always @(posedge clock) begin
        m_pipe[0] <= rdaddr;
        for (int i = 1; i < RL; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign rddata = mem[m_pipe[RL-1]];

    // Reference raster: pixel index p counts clocks since the raster started.
    function automatic int mx(int p); return p % HT; endfunction
    function automatic int my(int p); return (p / HT) % VT; endfunction
    function automatic logic mde(int p); return (mx(p) < HA) && (my(p) < VA); endfunction
    function automatic logic mhs(int p); return (mx(p) >= HSS) && (mx(p) < HSE); endfunction
    function automatic logic mvs(int p); return (my(p) >= VSS) && (my(p) < VSE); endfunction
    function automatic int maddr(int p); return (my(p) % LINES) * BUF + mx(p); endfunction
    function automatic logic [23:0] mvid(int p); return mde(p) ? mem[maddr(p)] : 24'd0; endfunction

    task automatic do_reset;
        starttrigger = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic pulse_trigger;
        @(posedge clock);
        #1 starttrigger = 1'b1;
        @(posedge clock);
        #1 starttrigger = 1'b0;
    endtask

    task automatic test_reset;
        logic [66:0] obs;
        #2 reset_n = 1'b0;
        #1;
        obs = {running, rden, de, hsync, vsync, video_out, counterX, counterY, rdaddr};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h expected=0", obs);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            obs = {running, rden, de, hsync, vsync, video_out, counterX, counterY, rdaddr};
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL idle_zero cyc=%0d got=%h expected=0", i, obs);
            end
        end
    endtask

    task automatic test_frames;
        int n_de = 0, n_hs = 0, n_vs = 0, line_de = 0, p;
        do_reset();
        repeat ($urandom_range(3, 20)) @(posedge clock);
        pulse_trigger();
        for (int k = 0; k < 2 * FRAME + RL + 2; k++) begin
            @(negedge clock);
            total++;
            if (running !== 1'b1 || counterX !== 12'(mx(k)) || counterY !== 12'(my(k))) begin
                bad++;
                $display("FAIL counters k=%0d got run=%b x=%0d y=%0d expected run=1 x=%0d y=%0d",
                         k, running, counterX, counterY, mx(k), my(k));
            end
            total++;
            if (k == 0) begin
                if (rden !== 1'b0) begin
                    bad++;
                    $display("FAIL rden_first k=0 got=%b expected=0", rden);
                end
            end else if (rden !== mde(k-1) || (mde(k-1) && rdaddr !== AW'(maddr(k-1)))) begin
                bad++;
                $display("FAIL read k=%0d got rden=%b addr=%0d expected rden=%b addr=%0d",
                         k, rden, rdaddr, mde(k-1), maddr(k-1));
            end
            total++;
            if (k < RL + 2) begin
                if ({de, hsync, vsync, video_out} !== '0) begin
                    bad++;
                    $display("FAIL pipe_fill k=%0d got de=%b hs=%b vs=%b vid=%h expected 0",
                             k, de, hsync, vsync, video_out);
                end
            end else begin
                p = k - RL - 2;
                if (de !== mde(p) || hsync !== mhs(p) || vsync !== mvs(p) || video_out !== mvid(p)) begin
                    bad++;
                    $display("FAIL video p=%0d got de=%b hs=%b vs=%b vid=%h expected de=%b hs=%b vs=%b vid=%h",
                             p, de, hsync, vsync, video_out, mde(p), mhs(p), mvs(p), mvid(p));
                end
                if (de === 1'b1) begin n_de++; line_de++; end
                if (hsync === 1'b1) n_hs++;
                if (vsync === 1'b1) n_vs++;
                if (mx(p) == HT - 1) begin
                    if (my(p) < VA) begin
                        total++;
                        if (line_de != HA) begin
                            bad++;
                            $display("FAIL line_de y=%0d got=%0d expected=%0d", my(p), line_de, HA);
                        end
                    end
                    line_de = 0;
                end
            end
        end
        total++;
        if (n_de != 2 * HA * VA) begin
            bad++;
            $display("FAIL de_total got=%0d expected=%0d", n_de, 2 * HA * VA);
        end
        total++;
        if (n_hs != 2 * VT * (HSE - HSS)) begin
            bad++;
            $display("FAIL hs_total got=%0d expected=%0d", n_hs, 2 * VT * (HSE - HSS));
        end
        total++;
        if (n_vs != 2 * HT * (VSE - VSS)) begin
            bad++;
            $display("FAIL vs_total got=%0d expected=%0d", n_vs, 2 * HT * (VSE - VSS));
        end
    endtask

    task automatic test_reset_midframe;
        int rx, ry;
        logic found = 1'b0;
        logic [66:0] obs;
        do_reset();
        pulse_trigger();
        rx = $urandom_range(1, HT - 1);
        ry = $urandom_range(1, VA - 1);
        for (int i = 0; i < FRAME + 10 && !found; i++) begin
            @(negedge clock);
            if (counterX == 12'(rx) && counterY == 12'(ry)) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midframe_wait got=timeout expected x=%0d y=%0d", rx, ry);
        end
        #1 reset_n = 1'b0;
        #1;
        obs = {running, rden, de, hsync, vsync, video_out, counterX, counterY, rdaddr};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midframe_async got=%h expected=0", obs);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            obs = {running, rden, de, hsync, vsync, video_out, counterX, counterY, rdaddr};
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d got=%h expected=0", i, obs);
            end
        end
    endtask

    task automatic test_second_trigger;
        int rx, ry;
        logic found = 1'b0;
        do_reset();
        pulse_trigger();
        rx = $urandom_range(1, HT - 3);
        ry = $urandom_range(1, VT - 1);
        for (int i = 0; i < FRAME + 10 && !found; i++) begin
            @(negedge clock);
            if (counterX == 12'(rx) && counterY == 12'(ry)) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL second_wait got=timeout expected x=%0d y=%0d", rx, ry);
        end
        starttrigger = 1'b1;
        @(posedge clock);
        #1 starttrigger = 1'b0;
        @(negedge clock);
`ifdef RAM2VIDEO_RESYNC_EN
        total++;
        if (running !== 1'b1 || counterX !== 12'd0 || counterY !== 12'd0) begin
            bad++;
            $display("FAIL resync_cnt got run=%b x=%0d y=%0d expected run=1 x=0 y=0",
                     running, counterX, counterY);
        end
        @(negedge clock);
        total++;
        if (rden !== 1'b1 || rdaddr !== '0 || counterX !== 12'd1) begin
            bad++;
            $display("FAIL resync_addr got rden=%b addr=%0d x=%0d expected rden=1 addr=0 x=1",
                     rden, rdaddr, counterX);
        end
`else
        total++;
        if (running !== 1'b1 || counterX !== 12'(rx + 1) || counterY !== 12'(ry)) begin
            bad++;
            $display("FAIL ignore_cnt got run=%b x=%0d y=%0d expected run=1 x=%0d y=%0d",
                     running, counterX, counterY, rx + 1, ry);
        end
        @(negedge clock);
        total++;
        if (counterX !== 12'(rx + 2) || counterY !== 12'(ry)) begin
            bad++;
            $display("FAIL ignore_cnt2 got x=%0d y=%0d expected x=%0d y=%0d",
                     counterX, counterY, rx + 2, ry);
        end
`endif
    endtask

    task automatic test_trigger_at_origin;
        do_reset();
        pulse_trigger();
        starttrigger = 1'b1;
        @(posedge clock);
        #1 starttrigger = 1'b0;
        @(negedge clock);
        total++;
        if (running !== 1'b1 || counterX !== 12'd1 || counterY !== 12'd0) begin
            bad++;
            $display("FAIL origin_cnt got run=%b x=%0d y=%0d expected run=1 x=1 y=0",
                     running, counterX, counterY);
        end
        @(negedge clock);
        total++;
        if (counterX !== 12'd2 || rden !== 1'b1 || rdaddr !== AW'(1)) begin
            bad++;
            $display("FAIL origin_read got x=%0d rden=%b addr=%0d expected x=2 rden=1 addr=1",
                     counterX, rden, rdaddr);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 24'($urandom);
        test_reset();
        test_frames();
        test_reset_midframe();
        test_second_trigger();
        test_trigger_at_origin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram2video_reader.md
Name: ram2video_reader

Overview:
Downstream consumer of the capture line buffer. Reads buffered RGB pixels from the read port of the dual-port RAM and regenerates a progressive output raster (pixel data, hsync, vsync, data-enable) for the HDMI transmitter. Starts its raster on the capture side's start trigger, so reads always trail writes by a fixed number of lines. All read-side timing and addressing is owned here.

Parameters:
H_TOTAL, 800, total pixels per output line
H_ACTIVE, 640, active pixels per line (x < H_ACTIVE)
H_SYNC_START, 656, first x with hsync asserted
H_SYNC_END, 752, first x with hsync deasserted
V_TOTAL, 525, total lines per frame
V_ACTIVE, 480, active lines (y < V_ACTIVE)
V_SYNC_START, 490, first y with vsync asserted
V_SYNC_END, 492, first y with vsync deasserted
BUFFER_LINE_LENGTH, 640, RAM words per buffered line
RAM_NUMWORDS, 10240, RAM depth (16 lines)
RAM_ADDRESS_BITS, 14, RAM address width
RD_LATENCY, 2, RAM read latency in clocks, address to data

Ports:
clock  in  1  pixel clock of the output raster
reset_n  in  1  asynchronous active-low reset
starttrigger  in  1  one-cycle pulse, synchronous to clock (CDC done at top level): capture reached trigger address
rddata  in  24  RAM read data {R,G,B}
rdaddr  out  RAM_ADDRESS_BITS  RAM read address
rden  out  1  RAM read enable
video_out  out  24  output pixel {R,G,B}
de  out  1  data enable
hsync  out  1  horizontal sync, active high
vsync  out  1  vertical sync, active high
counterX  out  12  current raster x (pre-pipeline)
counterY  out  12  current raster y (pre-pipeline)
running  out  1  raster active (state RUNNING)

Behaviour:
- Clock is clock; reset is asynchronous and active-low, on reset_n.
- Reset (async, reset_n=0): state WAIT_TRIGGER. counterX=0, counterY=0, line base=0. rdaddr=0, rden=0, video_out=0, de=0, hsync=0, vsync=0, running=0. All pipeline stages are cleared.
- Reset deasserted mid-frame: behaviour is identical to power-up, and the block waits for the next trigger.
- FSM WAIT_TRIGGER: counters held at 0, all outputs 0. When starttrigger=1 in cycle T: state RUNNING from T+1, running=1 at T+1, counterX=0 and counterY=0 at T+1.
- FSM RUNNING: counterX increments every clock and wraps H_TOTAL-1 -> 0. On that wrap counterY increments; counterY wraps V_TOTAL-1 -> 0.
- In RUNNING, starttrigger is ignored (see Optional Feature).
- Address generation: line base starts at 0 at y=0. It is updated when counterX==H_TOTAL-1 and counterY<V_ACTIVE:
  - If base+BUFFER_LINE_LENGTH >= RAM_NUMWORDS, base becomes 0.
  - Otherwise base becomes base+BUFFER_LINE_LENGTH.
  - At frame wrap (y: V_TOTAL-1 -> 0), base is forced to 0.
- Read: rdaddr/rden are registered, 1 clock after the counters. When x<H_ACTIVE and y<V_ACTIVE: rden=1 and rdaddr=base+x. Otherwise rden=0 and rdaddr holds its previous value.
- Pipeline: de, hsync and vsync are computed from the counters. They are delayed so that they, and video_out, appear exactly RD_LATENCY+1 clocks after the corresponding rdaddr. Total latency from counters to outputs is RD_LATENCY+2.
- video_out = rddata when the delayed de=1, else 24'd0.
- hsync = (H_SYNC_START <= x < H_SYNC_END); vsync = (V_SYNC_START <= y < V_SYNC_END). Both are delayed by the same pipeline.
- Width rules: counters are 12 bit, unsigned. Address arithmetic is done in RAM_ADDRESS_BITS+1 bits before the compare.

Optional Feature:
RAM2VIDEO_RESYNC_EN
- Defined: in RUNNING, a starttrigger pulse with (counterX,counterY) != (0,0) forces counterX=0, counterY=0 and base=0 on the next clock. The pipeline is not flushed; stale outputs drain naturally. A trigger arriving exactly at (0,0) has no effect. This lets the raster lock to capture-side drift.
- Not defined: starttrigger is only honoured in WAIT_TRIGGER. Once RUNNING, the raster free-runs until reset.

Test Plan:
- Reset, no trigger for 2000 clocks -> running=0, rden=0, de=0, hsync=0, vsync=0, video_out=0 throughout.
- Trigger pulse at cycle 10 -> running=1 at cycle 11; first rden=1 with rdaddr=0 at cycle 12; de=1 first at cycle 15 (RD_LATENCY=2).
- RAM model returning data = address -> line 0 outputs 0..639; line 1 outputs 640..1279; line 16 wraps to 0..639; y=0 of the next frame restarts at address 0.
- Raster check over 2 frames -> 640 de pixels per active line, 480 de lines; hsync high 96 clocks per line; vsync high 2 lines (y=490,491); period 800x525.
- Assert reset_n low at x=300,y=100, then release -> all outputs 0 immediately (async); no output until a new trigger.
- Second trigger at x=123,y=45 -> with RAM2VIDEO_RESYNC_EN: counters are (0,0) next clock and rdaddr restarts at 0; without it: counters continue to (124,45).
